axi4_lite_reg_bank: RTL and testbench

AXI4_LITE_REG_BANK -- requirements
Module: axi4_lite_reg_bank

---
 rtl/axi_lib_pkg.sv | 24 ++
 rtl/axi4_lite_reg_bank_if.sv | 52 +++++
 rtl/axi4_lite_addr_decode.sv | 48 ++++
 rtl/axi4_lite_reg_bank.sv | 203 ++++++++++++++++++++
 tb/tb_axi4_lite_reg_bank.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lib_pkg.sv
// axi_lib_pkg: shared AXI4-Lite response codes, write/read FSM state
// encodings and an index-width helper for the register bank slice.
package axi_lib_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_VALID
    } rd_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_bank_if.sv
// axi4_lite_reg_bank_if: AXI4-Lite AW/W/B/AR/R channel bundle.
// Ports: s_aw*, s_w*, s_b*, s_ar*, s_r*; master/slave modports.
interface axi4_lite_reg_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;

    modport master (
        output s_awaddr, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wvalid,
        input  s_wready,
        input  s_bresp, s_bvalid,
        output s_bready,
        output s_araddr, s_arvalid,
        input  s_arready,
        input  s_rdata, s_rresp, s_rvalid,
        output s_rready
    );

    modport slave (
        input  s_awaddr, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wvalid,
        output s_wready,
        output s_bresp, s_bvalid,
        input  s_bready,
        input  s_araddr, s_arvalid,
        output s_arready,
        output s_rdata, s_rresp, s_rvalid,
        input  s_rready
    );

endinterface

// File: rtl/axi4_lite_addr_decode.sv
// axi4_lite_addr_decode: registered address-to-register decode.
// Ports: clk, rst_n, en (capture), addr -> hit (mapped), idx.
module axi4_lite_addr_decode
    import axi_lib_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_REGS   = 16,
    parameter int                    IDX_W      = idx_width(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam logic [63:0] SPAN = 64'(NUM_REGS) * 64'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ADDR_WIDTH'(BYTES - 1);

    logic [ADDR_WIDTH:0]   diff;
    logic [ADDR_WIDTH-1:0] off;
    logic                  hit_d;

    // The extra top bit of diff is the borrow: set when addr < BASE_ADDR.
    always_comb begin
        diff  = {1'b0, addr} - {1'b0, BASE_ADDR};
        off   = diff[ADDR_WIDTH-1:0];
        hit_d = !diff[ADDR_WIDTH]
              && (64'(off) < SPAN)
              && ((off & ALIGN) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit <= 1'b0;
            idx <= '0;
        end else if (en) begin
            hit <= hit_d;
            idx <= IDX_W'(off >> LSB);
        end
    end

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// axi4_lite_reg_bank: AXI4-Lite slave register bank with RO, COR and
// write-trigger registers. Ports: clk, rst_n, s_axi (slave channels),
// i_hw_we/i_hw_wdata (hw writes), o_regs (contents), o_write_trigger.
module axi4_lite_reg_bank
    import axi_lib_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0]   COR_MASK   = '0,
    parameter logic [NUM_REGS-1:0]   TRIG_MASK  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    axi4_lite_reg_bank_if.slave            s_axi,
    input  logic [NUM_REGS-1:0]            i_hw_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_wdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_write_trigger
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = idx_width(NUM_REGS);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic                  aw_held, w_held;
    logic                  aw_hs, w_hs, ar_hs;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTES-1:0]      wstrb_q;
    logic                  w_hit, r_hit;
    logic [IDX_W-1:0]      w_idx, r_idx;
    logic                  w_ok, w_commit, r_fetch;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Handshakes are built from state, not from the ready outputs,
    // so the FSM process has no self-referential inputs.
    assign aw_hs = s_axi.s_awvalid && (w_state == W_IDLE) && !aw_held;
    assign w_hs  = s_axi.s_wvalid  && (w_state == W_IDLE) && !w_held;
    assign ar_hs = s_axi.s_arvalid && (r_state == R_IDLE);

    assign w_ok     = w_hit && !RO_MASK[w_idx];
    assign w_commit = (w_state == W_EXEC) && w_ok;
    assign r_fetch  = (r_state == R_FETCH);

    axi4_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_aw_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (aw_hs),
        .addr  (s_axi.s_awaddr),
        .hit   (w_hit),
        .idx   (w_idx)
    );

    axi4_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_ar_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ar_hs),
        .addr  (s_axi.s_araddr),
        .hit   (r_hit),
        .idx   (r_idx)
    );

    // Write FSM
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next          = w_state;
        s_axi.s_awready = 1'b0;
        s_axi.s_wready  = 1'b0;
        s_axi.s_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi.s_awready = !aw_held;
                s_axi.s_wready  = !w_held;
                if ((aw_held || aw_hs) && (w_held || w_hs))
                    w_next = W_EXEC;
            end
            W_EXEC: w_next = W_RESP;
            W_RESP: begin
                s_axi.s_bvalid = 1'b1;
                if (s_axi.s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_SLVERR;
        end else if (w_state == W_EXEC) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi.s_wdata;
                wstrb_q <= s_axi.s_wstrb;
            end
        end
    end

    assign s_axi.s_bresp = bresp_q;

    // Read FSM
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next          = r_state;
        s_axi.s_arready = 1'b0;
        s_axi.s_rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi.s_arready = 1'b1;
                if (s_axi.s_arvalid) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_VALID;
            R_VALID: begin
                s_axi.s_rvalid = 1'b1;
                if (s_axi.s_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Captured from storage before this edge's updates land, so a
    // concurrent write or hw update returns the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
        end else if (r_fetch) begin
            rdata_q <= r_hit ? regs[r_idx] : '0;
            rresp_q <= r_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi.s_rdata = rdata_q;
    assign s_axi.s_rresp = rresp_q;

    // Storage: hardware write beats AXI write beats clear-on-read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_hw_we[i]) begin
                    regs[i] <= i_hw_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_commit && w_idx == IDX_W'(i)) begin
                    for (int b = 0; b < BYTES; b++)
                        if (wstrb_q[b])
                            regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end else if (r_fetch && r_hit && COR_MASK[i]
                             && r_idx == IDX_W'(i)) begin
                    regs[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        o_write_trigger = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_commit && w_idx == IDX_W'(i) && TRIG_MASK[i])
                o_write_trigger[i] = 1'b1;
    end

    always_comb begin
        o_regs = '0;
        for (int i = 0; i < NUM_REGS; i++)
            o_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// tb_axi4_lite_reg_bank: directed AXI4-Lite register bank bench with a
// cycle-level register/trigger model checked on every falling edge.
module tb_axi4_lite_reg_bank;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          NREG = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [15:0] RO   = 16'h0008;
    localparam logic [15:0] COR  = 16'h0010;
    localparam logic [15:0] TRIG = 16'h0001;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SERR = 2'b10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREG-1:0]      hw_we;
    logic [NREG*DW-1:0]   hw_wdata;
    logic [NREG*DW-1:0]   regs_out;
    logic [NREG-1:0]      trig;

    axi4_lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_reg_bank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (BASE),
        .NUM_REGS   (NREG),
        .RO_MASK    (RO),
        .COR_MASK   (COR),
        .TRIG_MASK  (TRIG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axi           (bus),
        .i_hw_we         (hw_we),
        .i_hw_wdata      (hw_wdata),
        .o_regs          (regs_out),
        .o_write_trigger (trig)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          trig_cnt = 0;
    bit          chk_en = 1'b0;
    logic [31:0] model_regs [NREG];
    logic [NREG-1:0] exp_trig;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic bit mapped(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(NREG * 4)) && ((a % 4) == 0);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) model_regs[i] = '0;
        exp_trig = '0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NREG; i++)
                check($sformatf("o_regs[%0d]", i),
                      regs_out[i*DW +: DW], model_regs[i]);
            check("o_write_trigger", 32'(trig), 32'(exp_trig));
            if (trig[0]) trig_cnt++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_bvalid"},  32'(bus.s_bvalid),  0);
        check({tag, "_rvalid"},  32'(bus.s_rvalid),  0);
        check({tag, "_rdata"},   bus.s_rdata,        0);
        check({tag, "_rresp"},   32'(bus.s_rresp),   32'(SERR));
        check({tag, "_bresp"},   32'(bus.s_bresp),   32'(SERR));
        check({tag, "_awready"}, 32'(bus.s_awready), 1);
        check({tag, "_wready"},  32'(bus.s_wready),  1);
        check({tag, "_arready"}, 32'(bus.s_arready), 1);
    endtask

    task automatic hw_write(input int i, input logic [31:0] d);
        hw_we = 16'(1) << i;
        hw_wdata[i*DW +: DW] = d;
        @(posedge clk);
        model_regs[i] = d;
        #1;
        hw_we = '0;
    endtask

    task automatic wr_handshake(input logic [31:0] addr,
                                input logic [31:0] data,
                                input logic [3:0] strb,
                                input int w_lead, output bit ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        bus.s_awaddr = addr;
        bus.s_wdata  = data;
        bus.s_wstrb  = strb;
        bus.s_wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (cyc == w_lead && !aw_done) bus.s_awvalid = 1'b1;
            @(negedge clk);
            aw_hs = bus.s_awvalid && bus.s_awready;
            w_hs  = bus.s_wvalid && bus.s_wready;
            @(posedge clk);
            #1;
            if (aw_hs) begin aw_done = 1; bus.s_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.s_wvalid = 1'b0;  end
            cyc++;
        end
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        ok = aw_done && w_done;
        check("wr_handshake", 32'(ok), 1);
    endtask

    task automatic wr_finish(input logic [31:0] addr,
                             input logic [31:0] data,
                             input logic [3:0] strb, input int stall);
        bit ok_w;
        int i;
        i    = idx_of(addr);
        ok_w = mapped(addr) && !RO[i];
        if (ok_w && TRIG[i]) exp_trig = 16'(1) << i;
        @(negedge clk);
        check("bvalid_exec", 32'(bus.s_bvalid), 0);
        @(posedge clk);
        if (ok_w)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_regs[i][b*8 +: 8] = data[b*8 +: 8];
        exp_trig = '0;
        #1;
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            check("bvalid", 32'(bus.s_bvalid), 1);
            check("bresp", 32'(bus.s_bresp), ok_w ? 32'(OKAY) : 32'(SERR));
            if (k < stall) begin @(posedge clk); #1; end
        end
        bus.s_bready = 1'b1;
        @(posedge clk);
        #1;
        bus.s_bready = 1'b0;
        @(negedge clk);
        check("bvalid_clr", 32'(bus.s_bvalid), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr,
                             input logic [31:0] data,
                             input logic [3:0] strb,
                             input int w_lead, input int stall);
        bit ok;
        wr_handshake(addr, data, strb, w_lead, ok);
        if (ok) wr_finish(addr, data, strb, stall);
    endtask

    task automatic rd_handshake(input logic [31:0] addr, output bit ok);
        bit hs;
        ok = 0;
        bus.s_araddr  = addr;
        bus.s_arvalid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            hs = bus.s_arvalid && bus.s_arready;
            @(posedge clk);
            #1;
            if (hs) ok = 1;
        end
        bus.s_arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hw_i,
                            input logic [31:0] hw_d, input int stall,
                            output logic [31:0] got);
        bit ok, m;
        int i;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        got = 'x;
        rd_handshake(addr, ok);
        if (!ok) return;
        m     = mapped(addr);
        i     = idx_of(addr);
        exp_d = m ? model_regs[i] : 32'h0;
        exp_r = m ? OKAY : SERR;
        if (hw_i >= 0) begin
            hw_we = 16'(1) << hw_i;
            hw_wdata[hw_i*DW +: DW] = hw_d;
        end
        @(negedge clk);
        check("rvalid_fetch", 32'(bus.s_rvalid), 0);
        @(posedge clk);
        if (m && COR[i]) model_regs[i] = '0;
        if (hw_i >= 0) model_regs[hw_i] = hw_d;
        #1;
        hw_we = '0;
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            if (k == 0) got = bus.s_rdata;
            check("rvalid", 32'(bus.s_rvalid), 1);
            check("rdata", bus.s_rdata, exp_d);
            check("rresp", 32'(bus.s_rresp), 32'(exp_r));
            if (k < stall) begin @(posedge clk); #1; end
        end
        bus.s_rready = 1'b1;
        @(posedge clk);
        #1;
        bus.s_rready = 1'b0;
        @(negedge clk);
        check("rvalid_clr", 32'(bus.s_rvalid), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        bit          ok;
        bus.s_awaddr = '0; bus.s_awvalid = 0;
        bus.s_wdata = '0;  bus.s_wstrb = '0; bus.s_wvalid = 0;
        bus.s_bready = 0;
        bus.s_araddr = '0; bus.s_arvalid = 0; bus.s_rready = 0;
        hw_we = '0;
        hw_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check_reset_vals("init");
        @(posedge clk);
        #1;

        // Byte-strobe merge, AW and W together
        axi_write(BASE + 32'h8, 32'h1122_3344, 4'hF, 0, 0);
        axi_write(BASE + 32'h8, 32'hA5A5_A5A5, 4'b0011, 0, 0);
        check("reg2_lit", regs_out[2*DW +: DW], 32'h1122_A5A5);
        check("model_reg2_lit", model_regs[2], 32'h1122_A5A5);

        // W two cycles ahead of AW
        axi_write(BASE + 32'h4, 32'h0BAD_F00D, 4'hF, 2, 0);
        check("reg1_lit", regs_out[1*DW +: DW], 32'h0BAD_F00D);

        // Read-only register keeps its hw value
        hw_write(3, 32'hCAFE_0003);
        axi_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 0, 0);
        check("reg3_ro_lit", regs_out[3*DW +: DW], 32'hCAFE_0003);

        // One past the last register
        axi_write(BASE + 32'h40, 32'h1234_5678, 4'hF, 0, 0);

        // Reads: mapped, out of range, misaligned, below base, last reg
        axi_read(BASE + 32'h8, -1, 0, 0, got);
        check("rd_reg2_lit", got, 32'h1122_A5A5);
        axi_read(BASE + 32'h100, -1, 0, 0, got);
        check("rd_unmapped_lit", got, 32'h0);
        axi_read(BASE + 32'h2, -1, 0, 0, got);
        check("rd_misaligned_lit", got, 32'h0);
        axi_read(BASE - 32'h4, -1, 0, 0, got);
        axi_read(BASE + 32'h3C, -1, 0, 0, got);

        // Clear-on-read register 4
        axi_write(BASE + 32'h10, 32'h5, 4'hF, 0, 0);
        axi_read(BASE + 32'h10, -1, 0, 0, got);
        check("cor_first_lit", got, 32'h5);
        axi_read(BASE + 32'h10, -1, 0, 0, got);
        check("cor_second_lit", got, 32'h0);
        axi_write(BASE + 32'h10, 32'h5, 4'hF, 0, 0);
        axi_read(BASE + 32'h10, 4, 32'hDEAD_BEEF, 0, got);
        check("cor_hw_ret_lit", got, 32'h5);
        check("cor_hw_reg_lit", regs_out[4*DW +: DW], 32'hDEAD_BEEF);
        axi_read(BASE + 32'h10, -1, 0, 0, got);
        check("cor_hw_next_lit", got, 32'hDEAD_BEEF);

        // Back-pressure on R and B, trigger pulse width
        axi_read(BASE + 32'h4, -1, 0, 10, got);
        trig_cnt = 0;
        axi_write(BASE + 32'h0, 32'h1234_5678, 4'hF, 0, 10);
        check("trig_pulse_cycles", 32'(trig_cnt), 1);
        check("reg0_lit", regs_out[0 +: DW], 32'h1234_5678);

        // Reset while a write is executing
        wr_handshake(BASE + 32'h14, 32'h55, 4'hF, 0, ok);
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_exec");
        repeat (5) begin
            @(negedge clk);
            check("rst_exec_no_b", 32'(bus.s_bvalid), 0);
        end
        @(posedge clk);
        #1;

        // Reset while read data is waiting
        hw_write(6, 32'h66);
        rd_handshake(BASE + 32'h18, ok);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rvalid_pre_rst", 32'(bus.s_rvalid), 1);
        check("rdata_pre_rst", bus.s_rdata, 32'h66);
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_rvalid");
        repeat (5) begin
            @(negedge clk);
            check("rst_rv_no_r", 32'(bus.s_rvalid), 0);
            check("rst_rv_no_b", 32'(bus.s_bvalid), 0);
        end
        @(posedge clk);
        #1;

        // Normal operation after reset
        axi_write(BASE + 32'h8, 32'h0000_0001, 4'hF, 0, 0);
        axi_read(BASE + 32'h8, -1, 0, 0, got);
        check("post_rst_lit", got, 32'h1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
